// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
//  - state_e: sequencer FSM state encodings.
//  - CLK_HZ: board PLL clock frequency, used to derive the default timing parameters.
//  - cnt_width(): counter width helper that never returns zero.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ = 42_000_000;

  // About 100 us of lock, rounded down to a power of two: 4096 cycles (~97.5 us).
  localparam int unsigned DEFAULT_HOLD_CYCLES = 2 ** ($clog2(CLK_HZ / 10_000) - 1);

  // 10 ms of stable button level.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-facing signal bundle of the reset sequencer.
//  isLocked   PLL lock flag (asynchronous)
//  buttonIn   raw board button (asynchronous, bouncing)
//  coreReset  active-high synchronous reset for the J1 core
//  resetDone  high while the core runs
//  lockLost   sticky lock-loss indication
// master: the board/environment side; slave: the sequencer.
interface reset_sequencer_if;

  logic isLocked;
  logic buttonIn;
  logic coreReset;
  logic resetDone;
  logic lockLost;

  modport master (
    output isLocked,
    output buttonIn,
    input  coreReset,
    input  resetDone,
    input  lockLost
  );

  modport slave (
    input  isLocked,
    input  buttonIn,
    output coreReset,
    output resetDone,
    output lockLost
  );

endinterface

// File: rtl/reset_sequencer_sync_debounce.sv
// Button synchronizer and debouncer.
//  clk           sequencer clock
//  reset         synchronous active-high reset
//  btn_i         raw button, asynchronous to clk
//  btn_stable_o  debounced button level, 1 = pressed
// The raw button passes through SYNC_STAGES flops, is normalised to pressed=1 and is then
// accepted only after it has differed from the accepted level for DEBOUNCE_CYCLES cycles.
module reset_sequencer_sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic btn_stable_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_sync;
  logic                   stable_q, stable_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
  end

  assign btn_sync = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  // Counter runs only while the synchronized level disagrees with the accepted one; any
  // agreeing cycle (a bounce back) clears it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (btn_sync != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = btn_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_stable_o = stable_q;

endmodule

// File: rtl/reset_sequencer.sv
// Core reset sequencer for the J1 system on the PLL clock domain.
//  clk    PLL output clock, only clock of the block
//  reset  synchronous active-high reset of this block
//  bus    slave side of reset_sequencer_if:
//           isLocked/buttonIn in (asynchronous), coreReset/resetDone/lockLost out (registered)
// The core is held in reset until the synchronized lock has been stable for HOLD_CYCLES
// with the button released; lock loss or a debounced press puts it back into reset.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned HOLD_CYCLES       = DEFAULT_HOLD_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               reset,
  reset_sequencer_if.slave  bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic                   lock_sync;
  logic                   btn_stable;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             core_reset_q, core_reset_d;
  logic             done_q, done_d;
  logic             lost_q, lost_d;

  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], bus.isLocked};
  end

  assign lock_sync = lock_sync_q[SYNC_STAGES-1];

  reset_sequencer_sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (BUTTON_ACTIVE_LOW)
  ) u_sync_debounce (
    .clk          (clk),
    .reset        (reset),
    .btn_i        (bus.buttonIn),
    .btn_stable_o (btn_stable)
  );

  // Priority in every state: lock loss, then button, then hold counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
        end else if (btn_stable) begin
          hold_d = '0;
        end else if (hold_q == HoldMax) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (btn_stable) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        hold_d  = '0;
      end
    endcase
    // Outputs follow the next state so they switch on the same edge as the state does.
    core_reset_d = (state_d != RUN);
    done_d       = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sync_q  <= '0;
      state_q      <= WAIT_LOCK;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      lock_sync_q  <= lock_sync_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      lost_q       <= lost_d;
    end
  end

  assign bus.coreReset = core_reset_q;
  assign bus.resetDone = done_q;
  assign bus.lockLost  = lost_q;

endmodule
